// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with arbitrary (non power-of-two)
// depth, occupancy counter, full/empty/almost flags and registered
// wr_ack/overflow/underflow handshake pulses.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through: data_out
// shows the head word combinationally instead of a registered read result.
module param_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 7,
  parameter int AE_THRESH  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FIFO_WIDTH-1:0]             data_in,
  input  logic                              wr_en,
  input  logic                              rd_en,
  output logic [FIFO_WIDTH-1:0]             data_out,
  output logic                              wr_ack,
  output logic                              overflow,
  output logic                              underflow,
  output logic                              full,
  output logic                              empty,
  output logic                              almostfull,
  output logic                              almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH-1);

  // Reject nonsensical configurations while elaborating.
  if (FIFO_DEPTH < 2 || !(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < FIFO_DEPTH)) begin : g_param_err
    $fatal(1, "param_fifo: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  // Acceptance is judged on the pre-edge occupancy, so a write never lands
  // through a full FIFO and a read never bypasses an empty one.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Occupancy flags, decoded straight from the counter.
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C) && !full;
  assign almostempty = (count <= AE_C) && !empty;

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, counter and one-cycle handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible as soon as it has been written.
  assign data_out = mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] dout_r;

  // Registered read port: loads only on an accepted read, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)         dout_r <= '0;
    else if (rd_acc) dout_r <= mem[rd_ptr];
  end

  assign data_out = dout_r;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: the stimulus side updates a queue-based
// reference model and pushes expected outputs; a negedge monitor pops and
// compares. A second depth-5 instance exercises pointer wrap.
module tb_param_fifo;

  localparam int D  = 8;
  localparam int AF = 7;
  localparam int AE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [3:0]  count;

  logic        rst5 = 1'b1;
  logic [15:0] din5 = '0;
  logic        wr5 = 1'b0, rd5 = 1'b0;
  logic [15:0] dout5;
  logic        ack5, ovf5, unf5, full5, empty5, af5, ae5;
  logic [2:0]  count5;

  always #5 clk = ~clk;

  param_fifo dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .count(count)
  );

  param_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut5 (
    .clk(clk), .rst(rst5), .data_in(din5), .wr_en(wr5), .rd_en(rd5),
    .data_out(dout5), .wr_ack(ack5), .overflow(ovf5), .underflow(unf5),
    .full(full5), .empty(empty5), .almostfull(af5), .almostempty(ae5),
    .count(count5)
  );

  typedef struct {
    int          tag;
    int          cnt;
    bit          full, empty, af, ae, ack, ovf, unf;
    bit          chk_dout;
    logic [15:0] dout;
  } exp_t;

  typedef struct {
    int          tag;
    int          cnt;
    bit          chk_dout;
    logic [15:0] dout;
  } exp5_t;

  exp_t        exp_q[$];
  exp5_t       exp5_q[$];
  logic [15:0] mq[$];
  logic [15:0] m5[$];
  logic [15:0] dmodel = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  // Reference model step for the depth-8 instance, then one clock.
  task automatic step(bit rs, bit w, bit r, logic [15:0] d);
    exp_t e;
    int   sz;
    bit   aw, ar;
    rst = rs; wr_en = w; rd_en = r; data_in = d;
    sz = mq.size();
    e.ack = 0; e.ovf = 0; e.unf = 0;
    if (rs) begin
      mq.delete();
      dmodel = '0;
    end else begin
      aw = w && (sz < D);
      ar = r && (sz > 0);
      e.ack = aw;
      e.ovf = w && (sz == D);
      e.unf = r && (sz == 0);
      if (ar) dmodel = mq.pop_front();
      if (aw) mq.push_back(d);
    end
    e.cnt   = mq.size();
    e.full  = (e.cnt == D);
    e.empty = (e.cnt == 0);
    e.af    = (e.cnt >= AF) && !e.full;
    e.ae    = (e.cnt <= AE) && !e.empty;
`ifdef FIFO_FWFT_EN
    e.chk_dout = (mq.size() > 0);
    e.dout     = e.chk_dout ? mq[0] : '0;
`else
    e.chk_dout = 1'b1;
    e.dout     = dmodel;
`endif
    e.tag = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Model step for the depth-5 instance; patterns never over/underflow it.
  task automatic step5(bit rs, bit w, bit r, logic [15:0] d);
    exp5_t e;
    rst5 = rs; wr5 = w; rd5 = r; din5 = d;
    e.chk_dout = 1'b0;
    e.dout     = '0;
    if (rs) begin
      m5.delete();
`ifndef FIFO_FWFT_EN
      e.chk_dout = 1'b1;
`endif
    end else begin
`ifdef FIFO_FWFT_EN
      if (r) void'(m5.pop_front());
      if (w) m5.push_back(d);
      e.chk_dout = (m5.size() > 0);
      if (e.chk_dout) e.dout = m5[0];
`else
      if (r) begin
        e.dout     = m5.pop_front();
        e.chk_dout = 1'b1;
      end
      if (w) m5.push_back(d);
`endif
    end
    e.cnt = m5.size();
    e.tag = cyc;
    exp5_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every expectation whose clock edge has passed.
  always @(negedge clk) begin
    exp_t  e;
    exp5_t f;
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      e = exp_q.pop_front();
      chk("count",       32'(count),       32'(e.cnt));
      chk("full",        32'(full),        32'(e.full));
      chk("empty",       32'(empty),       32'(e.empty));
      chk("almostfull",  32'(almostfull),  32'(e.af));
      chk("almostempty", 32'(almostempty), 32'(e.ae));
      chk("wr_ack",      32'(wr_ack),      32'(e.ack));
      chk("overflow",    32'(overflow),    32'(e.ovf));
      chk("underflow",   32'(underflow),   32'(e.unf));
      if (e.chk_dout) chk("data_out", 32'(data_out), 32'(e.dout));
    end
    while (exp5_q.size() > 0 && exp5_q[0].tag < cyc) begin
      f = exp5_q.pop_front();
      chk("d5_count", 32'(count5), 32'(f.cnt));
      if (f.chk_dout) chk("d5_data_out", 32'(dout5), 32'(f.dout));
    end
  end

  initial begin
    int wp, rp;
    // Reset with a simultaneous write request that must be discarded.
    step(1, 1, 0, 16'h1234);
    step(0, 0, 0, 16'h0);
    // Fill to full: almostfull at 7, full (not almostfull) at 8.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 16'(i));
    // Write to a full FIFO is rejected and flagged.
    step(0, 1, 0, 16'hDEAD);
    step(0, 0, 0, 16'h0);
    // Drain in order, then read on empty.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 0, 16'h0);
    // Simultaneous read+write on empty: write lands, read underflows.
    step(0, 1, 1, 16'h0055);
    step(0, 0, 1, 16'h0);
    // Steady state at count 4 with 10 simultaneous read/write cycles.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0040 + 16'(i));
    for (int i = 0; i < 10; i++) step(0, 1, 1, 16'h0050 + 16'(i));
    // Count 5, then reset with a write pending.
    step(0, 1, 0, 16'h0077);
    step(1, 1, 0, 16'h0099);
    step(0, 0, 0, 16'h0);
    // Single word into an empty FIFO, then idle.
    step(0, 1, 0, 16'h00A5);
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    // Randomized traffic with three write/read biases and rare resets.
    for (int ph = 0; ph < 3; ph++) begin
      wp = 70 - 20 * ph;
      rp = 30 + 20 * ph;
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 79) == 0, $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < rp, 16'($urandom));
    end
    // Depth-5 instance: fill 4, 12 read/write pairs across the wrap, drain.
    step5(1, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step5(0, 1, 0, 16'h0100 + 16'(i));
    for (int i = 4; i < 16; i++) step5(0, 1, 1, 16'h0100 + 16'(i));
    for (int i = 0; i < 4; i++) step5(0, 0, 1, 16'h0);
    step5(0, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size() + exp5_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 8, number of words (>=2, any integer, not restricted to powers of two).
REQ-003 Parameter AF_THRESH, default 7, almostfull occupancy threshold.
REQ-004 Parameter AE_THRESH, default 1, almostempty occupancy threshold.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 data_in  input  FIFO_WIDTH  write data.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request.
REQ-010 data_out  output  FIFO_WIDTH  read data.
REQ-011 wr_ack  output  1  previous-cycle write accepted.
REQ-012 overflow  output  1  previous-cycle write rejected (full).
REQ-013 underflow  output  1  previous-cycle read rejected (empty).
REQ-014 full, empty, almostfull, almostempty  output  1 each  occupancy flags.
REQ-015 count  output  $clog2(FIFO_DEPTH+1)  current occupancy, 0..FIFO_DEPTH.

Function
REQ-016 Write accepted iff wr_en=1 and full=0; accepted data stored at wr_ptr on the same edge.
REQ-017 Read accepted iff rd_en=1 and empty=0; no read-through-write when empty, no write-through-read when full.
REQ-018 count: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither accepted.
REQ-019 wr_ptr/rd_ptr advance by 1 on accepted write/read and wrap from FIFO_DEPTH-1 to 0.
REQ-020 Default mode: data_out registered, loaded with mem[rd_ptr] on the edge of an accepted read (1-cycle latency); holds value otherwise, including on rejected reads.
REQ-021 wr_ack, overflow, underflow registered: 1 for exactly the cycle after the request edge, 0 otherwise.
REQ-022 overflow=1 after an edge with wr_en=1 and full=1; underflow=1 after an edge with rd_en=1 and empty=1.
REQ-023 Flags combinational from count: full=(count==FIFO_DEPTH), empty=(count==0).
REQ-024 almostfull=(count>=AF_THRESH) and not full; almostempty=(count<=AE_THRESH) and not empty.
REQ-025 Parameter violation (FIFO_DEPTH<2, or not 0<AE_THRESH<AF_THRESH<FIFO_DEPTH) shall cause an elaboration-time fatal error.

Reset
REQ-026 rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0; memory contents not cleared.
REQ-027 After reset: empty=1, full=0, almostfull=0, almostempty=0.
REQ-028 rst has priority over wr_en/rd_en in the same cycle; requests in that cycle are discarded without flags.

Configuration
REQ-029 Macro FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-030 Defined: data_out=mem[rd_ptr] combinationally, valid whenever empty=0; the first word appears the cycle after its write edge; an accepted read advances to the next word; all flags and handshake outputs unchanged.
REQ-031 Not defined: REQ-020 behaviour applies.

Verification
REQ-032 Reset, then 8 writes 0x0001..0x0008 (defaults) -> wr_ack=1 each cycle after, almostfull=1 at count=7, full=1 at count=8, almostfull=0 at count=8.
REQ-033 Full FIFO, wr_en=1 with 0xDEAD -> overflow=1 one cycle, count stays 8, 0xDEAD never read out.
REQ-034 8 reads after REQ-032 -> data_out 0x0001..0x0008 in order, 1 cycle after each rd_en; then rd_en on empty -> underflow=1, data_out holds 0x0008.
REQ-035 count=4, wr_en=rd_en=1 for 10 cycles -> count stays 4, FIFO order preserved; FIFO_DEPTH=5 build, 12 write/read pairs -> correct data across pointer wrap 4->0.
REQ-036 count=5, rst=1 with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, data_out=0.
REQ-037 FIFO_FWFT_EN defined, write 0x00A5 to empty FIFO -> data_out=0x00A5 and empty=0 the next cycle with no rd_en.
